// File: rtl/constants_pkg.sv
// constants_pkg: shared widths and enums for the GPU dispatch controller
package constants_pkg;
   localparam int ADDR_WIDTH = 16;
   typedef enum logic [1:0] {
      SET_BASE  = 2'b00,
      SET_COUNT = 2'b01,
      LAUNCH    = 2'b10,
      ABORT     = 2'b11
   } gpu_op_e;
   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      DRAIN,
      DONE
   } dispatch_state_e;
endpackage

// File: rtl/gpu_free_core_picker.sv
// gpu_free_core_picker: one-hot grant of the lowest-index free core
module gpu_free_core_picker #(
   parameter int NUM_CORES = 4
) (
   input  logic [NUM_CORES-1:0] i_free,
   output logic [NUM_CORES-1:0] o_grant,
   output logic                 o_any_free
);
   assign o_grant    = i_free & (~i_free + NUM_CORES'(1));
   assign o_any_free = |i_free;
endmodule

// File: rtl/gpu_dispatch_ctrl.sv
// gpu_dispatch_ctrl: decodes config/launch commands and dispatches kernel blocks to cores
module gpu_dispatch_ctrl #(
   parameter int ADDR_WIDTH = constants_pkg::ADDR_WIDTH,
   parameter int NUM_CORES  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [1:0]            i_op_code,
   input  logic [ADDR_WIDTH-1:0] i_cfg_data,
   output logic                  o_busy,
   output logic [NUM_CORES-1:0]  o_core_launch,
   output logic [ADDR_WIDTH-1:0] o_launch_block_id,
   output logic [ADDR_WIDTH-1:0] o_launch_base_addr,
   input  logic [NUM_CORES-1:0]  i_core_done,
   output logic                  o_kernel_done,
   output logic                  o_kernel_aborted
);
   import constants_pkg::*;
   gpu_op_e               w_op;
   dispatch_state_e       r_state, w_next_state;
   logic [ADDR_WIDTH-1:0] r_base, r_count, r_next_id, r_block_id, r_base_addr;
   logic [NUM_CORES-1:0]  r_core_busy, r_core_launch, w_grant;
   logic                  r_busy, r_kernel_done, r_kernel_aborted, r_aborted;
   logic                  w_any_free, w_launch_cmd, w_abort_cmd, w_cfg_ok, w_issue, w_done_state;

   assign w_op         = gpu_op_e'(i_op_code);
   assign w_cfg_ok     = i_start && r_state == IDLE;
   assign w_launch_cmd = w_cfg_ok && w_op == LAUNCH;
   assign w_abort_cmd  = i_start && w_op == ABORT && r_state != IDLE;

   gpu_free_core_picker #(.NUM_CORES(NUM_CORES)) u_picker (
      .i_free    (~r_core_busy),
      .o_grant   (w_grant),
      .o_any_free(w_any_free)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // next state: drain starts once every block is issued or on abort; done once all cores are idle
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     w_next_state = w_launch_cmd ? DISPATCH : IDLE;
         DISPATCH: w_next_state = (w_abort_cmd || r_next_id == r_count) ? DRAIN : DISPATCH;
         DRAIN:    w_next_state = (r_core_busy == '0) ? DONE : DRAIN;
         default:  w_next_state = IDLE;
      endcase
   end

   // outputs of the FSM: at most one block issued per cycle, never on the abort edge
   always_comb begin
      w_issue      = r_state == DISPATCH && !w_abort_cmd && w_any_free && r_next_id < r_count;
      w_done_state = r_state == DONE;
   end

   // config registers, dispatch bookkeeping and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base           <= '0;
         r_count          <= '0;
         r_next_id        <= '0;
         r_block_id       <= '0;
         r_base_addr      <= '0;
         r_core_busy      <= '0;
         r_core_launch    <= '0;
         r_busy           <= 1'b0;
         r_aborted        <= 1'b0;
         r_kernel_done    <= 1'b0;
         r_kernel_aborted <= 1'b0;
      end else begin
         if (w_cfg_ok && w_op == SET_BASE)  r_base  <= i_cfg_data;
         if (w_cfg_ok && w_op == SET_COUNT) r_count <= i_cfg_data;
         if (w_issue) begin
            r_block_id  <= r_next_id;
            r_base_addr <= r_base;
         end
         r_next_id        <= w_launch_cmd ? '0 : r_next_id + ADDR_WIDTH'(w_issue);
         r_core_busy      <= (r_core_busy & ~i_core_done) | (w_issue ? w_grant : '0);
         r_core_launch    <= w_issue ? w_grant : '0;
         r_busy           <= w_next_state != IDLE;
         r_aborted        <= w_launch_cmd ? 1'b0 : (r_aborted || w_abort_cmd);
         r_kernel_done    <= w_done_state;
         r_kernel_aborted <= w_done_state && (r_aborted || w_abort_cmd);
      end
   end

   assign o_busy             = r_busy;
   assign o_core_launch      = r_core_launch;
   assign o_launch_block_id  = r_block_id;
   assign o_launch_base_addr = r_base_addr;
   assign o_kernel_done      = r_kernel_done;
   assign o_kernel_aborted   = r_kernel_aborted;
endmodule
